// File: rtl/axi_arb_pkg.sv
// Shared encodings for axi_lite_master_arbiter: FSM state codes and BRESP values.
package axi_arb_pkg;

  // Read channel FSM states
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  // Write channel FSM states
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  // AXI response codes
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/rr_picker.sv
// Request picker for axi_lite_master_arbiter.
// Default: round-robin starting one past 'last'.
// With ARB_FIXED_PRIORITY_EN defined: lowest index wins and 'last' is ignored.
module rr_picker #(
  parameter int unsigned MASTERS = 2,
  localparam int unsigned IDXW = $clog2(MASTERS)
) (
  input  logic [MASTERS-1:0] req,
  input  logic [IDXW-1:0]    last,
  output logic [IDXW-1:0]    winner,
  output logic               any
);

  logic found;

`ifdef ARB_FIXED_PRIORITY_EN
  logic unused_last;
  assign unused_last = ^last;

  // Lowest requesting index wins
  always_comb begin
    winner = '0;
    found  = 1'b0;
    any    = |req;
    for (int unsigned k = 0; k < MASTERS; k++) begin
      if (!found && req[IDXW'(k)]) begin
        found  = 1'b1;
        winner = IDXW'(k);
      end
    end
  end
`else
  int unsigned idx;

  // First requester found searching upward from last+1, wrapping modulo MASTERS
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    any    = |req;
    for (int unsigned k = 1; k <= MASTERS; k++) begin
      idx = (32'(last) + k) % MASTERS;
      if (!found && req[IDXW'(idx)]) begin
        found  = 1'b1;
        winner = IDXW'(idx);
      end
    end
  end
`endif

endmodule

// File: rtl/axi_lite_master_arbiter.sv
// Shares one AXI-Lite upstream port (rv_axi_*) between MASTERS requesters.
// Read and write channels are arbitrated independently; a grant is held until
// the channel's transaction retires (R handshake / B handshake).
// Optional macro ARB_FIXED_PRIORITY_EN selects fixed priority instead of round-robin.
module axi_lite_master_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned MASTERS  = 2,
  parameter int unsigned BUSWIDTH = 32,
  localparam int unsigned IDXW = $clog2(MASTERS)
) (
  input  logic                         clk,
  input  logic                         rst,
  // Per-master side
  input  logic [32*MASTERS-1:0]        m_axi_araddr,
  input  logic [3*MASTERS-1:0]         m_axi_arprot,
  input  logic [MASTERS-1:0]           m_axi_arvalid,
  output logic [MASTERS-1:0]           m_axi_arready,
  output logic [BUSWIDTH*MASTERS-1:0]  m_axi_rdata,
  output logic [MASTERS-1:0]           m_axi_rvalid,
  input  logic [MASTERS-1:0]           m_axi_rready,
  input  logic [32*MASTERS-1:0]        m_axi_awaddr,
  input  logic [3*MASTERS-1:0]         m_axi_awprot,
  input  logic [MASTERS-1:0]           m_axi_awvalid,
  output logic [MASTERS-1:0]           m_axi_awready,
  input  logic [BUSWIDTH*MASTERS-1:0]  m_axi_wdata,
  input  logic [4*MASTERS-1:0]         m_axi_wstrb,
  input  logic [MASTERS-1:0]           m_axi_wvalid,
  output logic [MASTERS-1:0]           m_axi_wready,
  output logic [MASTERS-1:0]           m_b_valid,
  input  logic [MASTERS-1:0]           m_b_ready,
  output logic [2*MASTERS-1:0]         m_b_response,
  // Shared crossbar side
  output logic [31:0]                  rv_axi_araddr,
  output logic [2:0]                   rv_axi_arprot,
  output logic                         rv_axi_arvalid,
  input  logic                         rv_axi_arready,
  input  logic [BUSWIDTH-1:0]          rv_axi_rdata,
  input  logic                         rv_axi_rvalid,
  output logic                         rv_axi_rready,
  output logic [31:0]                  rv_axi_awaddr,
  output logic [2:0]                   rv_axi_awprot,
  output logic                         rv_axi_awvalid,
  input  logic                         rv_axi_awready,
  output logic [BUSWIDTH-1:0]          rv_axi_wdata,
  output logic [3:0]                   rv_axi_wstrb,
  output logic                         rv_axi_wvalid,
  input  logic                         rv_axi_wready,
  output logic                         rv_b_ready,
  input  logic                         rv_b_valid,
  input  logic [1:0]                   rv_b_response
);

  logic [1:0]      r_state, w_state;
  logic [IDXW-1:0] rgrant, wgrant;
  logic            aw_done, w_done;
  logic [IDXW-1:0] r_ptr, w_ptr;
  logic [IDXW-1:0] r_win, w_win;
  logic            r_any, w_any;

`ifdef ARB_FIXED_PRIORITY_EN
  assign r_ptr = '0;
  assign w_ptr = '0;
`else
  logic [IDXW-1:0] rlast, wlast;
  assign r_ptr = rlast;
  assign w_ptr = wlast;
`endif

  // Unpacked views of the flat per-master buses
  logic [31:0]         araddr_a [MASTERS];
  logic [2:0]          arprot_a [MASTERS];
  logic [31:0]         awaddr_a [MASTERS];
  logic [2:0]          awprot_a [MASTERS];
  logic [BUSWIDTH-1:0] wdata_a  [MASTERS];
  logic [3:0]          wstrb_a  [MASTERS];
  logic [BUSWIDTH-1:0] rdata_a  [MASTERS];
  logic [1:0]          bresp_a  [MASTERS];

  for (genvar i = 0; i < MASTERS; i++) begin : g_flat
    assign araddr_a[i] = m_axi_araddr[i*32 +: 32];
    assign arprot_a[i] = m_axi_arprot[i*3 +: 3];
    assign awaddr_a[i] = m_axi_awaddr[i*32 +: 32];
    assign awprot_a[i] = m_axi_awprot[i*3 +: 3];
    assign wdata_a[i]  = m_axi_wdata[i*BUSWIDTH +: BUSWIDTH];
    assign wstrb_a[i]  = m_axi_wstrb[i*4 +: 4];
    assign m_axi_rdata[i*BUSWIDTH +: BUSWIDTH] = rdata_a[i];
    assign m_b_response[i*2 +: 2] = bresp_a[i];
  end

  rr_picker #(
    .MASTERS (MASTERS)
  ) u_rd_pick (
    .req    (m_axi_arvalid),
    .last   (r_ptr),
    .winner (r_win),
    .any    (r_any)
  );

  rr_picker #(
    .MASTERS (MASTERS)
  ) u_wr_pick (
    .req    (m_axi_awvalid),
    .last   (w_ptr),
    .winner (w_win),
    .any    (w_any)
  );

  // Handshakes as seen by the crossbar; AW/W valids are masked once their beat is done
  logic ar_fwd, ar_hs, r_hs, aw_fwd, aw_hs, w_fwd, w_hs, b_hs;
  assign ar_fwd = m_axi_arvalid[rgrant];
  assign ar_hs  = ar_fwd && rv_axi_arready;
  assign r_hs   = rv_axi_rvalid && m_axi_rready[rgrant];
  assign aw_fwd = m_axi_awvalid[wgrant] && !aw_done;
  assign aw_hs  = aw_fwd && rv_axi_awready;
  assign w_fwd  = m_axi_wvalid[wgrant] && !w_done;
  assign w_hs   = w_fwd && rv_axi_wready;
  assign b_hs   = rv_b_valid && m_b_ready[wgrant];

  // Read FSM: arbitrate, forward AR, then wait for the R beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      rgrant  <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
      rlast   <= IDXW'(MASTERS - 1);
`endif
    end else begin
      case (r_state)
        R_IDLE: if (r_any) begin
          rgrant  <= r_win;
`ifndef ARB_FIXED_PRIORITY_EN
          rlast   <= r_win;
`endif
          r_state <= R_ADDR;
        end
        R_ADDR: if (ar_hs) r_state <= R_DATA;
        R_DATA: if (r_hs) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write FSM: arbitrate, collect AW and W in any order, then wait for B
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      wgrant  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
      wlast   <= IDXW'(MASTERS - 1);
`endif
    end else begin
      case (w_state)
        W_IDLE: if (w_any) begin
          wgrant  <= w_win;
`ifndef ARB_FIXED_PRIORITY_EN
          wlast   <= w_win;
`endif
          w_state <= W_ADDR;
        end
        W_ADDR: begin
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            w_state <= W_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        W_RESP: if (b_hs) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read-channel routing between the granted master and the crossbar
  always_comb begin
    rv_axi_araddr  = '0;
    rv_axi_arprot  = '0;
    rv_axi_arvalid = 1'b0;
    rv_axi_rready  = 1'b0;
    m_axi_arready  = '0;
    m_axi_rvalid   = '0;
    for (int i = 0; i < MASTERS; i++) rdata_a[i] = '0;
    case (r_state)
      R_ADDR: begin
        rv_axi_araddr         = araddr_a[rgrant];
        rv_axi_arprot         = arprot_a[rgrant];
        rv_axi_arvalid        = ar_fwd;
        m_axi_arready[rgrant] = rv_axi_arready;
      end
      R_DATA: begin
        rdata_a[rgrant]      = rv_axi_rdata;
        m_axi_rvalid[rgrant] = rv_axi_rvalid;
        rv_axi_rready        = m_axi_rready[rgrant];
      end
      default: ;
    endcase
  end

  // Write-channel routing between the granted master and the crossbar
  always_comb begin
    rv_axi_awaddr  = '0;
    rv_axi_awprot  = '0;
    rv_axi_awvalid = 1'b0;
    rv_axi_wdata   = '0;
    rv_axi_wstrb   = '0;
    rv_axi_wvalid  = 1'b0;
    rv_b_ready     = 1'b0;
    m_axi_awready  = '0;
    m_axi_wready   = '0;
    m_b_valid      = '0;
    for (int i = 0; i < MASTERS; i++) bresp_a[i] = '0;
    case (w_state)
      W_ADDR: begin
        rv_axi_awaddr         = awaddr_a[wgrant];
        rv_axi_awprot         = awprot_a[wgrant];
        rv_axi_awvalid        = aw_fwd;
        rv_axi_wdata          = wdata_a[wgrant];
        rv_axi_wstrb          = wstrb_a[wgrant];
        rv_axi_wvalid         = w_fwd;
        m_axi_awready[wgrant] = rv_axi_awready && !aw_done;
        m_axi_wready[wgrant]  = rv_axi_wready && !w_done;
      end
      W_RESP: begin
        m_b_valid[wgrant] = rv_b_valid;
        bresp_a[wgrant]   = rv_b_response;
        rv_b_ready        = m_b_ready[wgrant];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// Directed self-checking bench for axi_lite_master_arbiter (MASTERS=2, BUSWIDTH=32).
module tb_axi_lite_master_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] m_axi_araddr = '0;
  logic [5:0]  m_axi_arprot = '0;
  logic [1:0]  m_axi_arvalid = '0;
  logic [1:0]  m_axi_arready;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rvalid;
  logic [1:0]  m_axi_rready = '0;
  logic [63:0] m_axi_awaddr = '0;
  logic [5:0]  m_axi_awprot = '0;
  logic [1:0]  m_axi_awvalid = '0;
  logic [1:0]  m_axi_awready;
  logic [63:0] m_axi_wdata = '0;
  logic [7:0]  m_axi_wstrb = '0;
  logic [1:0]  m_axi_wvalid = '0;
  logic [1:0]  m_axi_wready;
  logic [1:0]  m_b_valid;
  logic [1:0]  m_b_ready = '0;
  logic [3:0]  m_b_response;
  logic [31:0] rv_axi_araddr;
  logic [2:0]  rv_axi_arprot;
  logic        rv_axi_arvalid;
  logic        rv_axi_arready = 1'b0;
  logic [31:0] rv_axi_rdata = '0;
  logic        rv_axi_rvalid = 1'b0;
  logic        rv_axi_rready;
  logic [31:0] rv_axi_awaddr;
  logic [2:0]  rv_axi_awprot;
  logic        rv_axi_awvalid;
  logic        rv_axi_awready = 1'b0;
  logic [31:0] rv_axi_wdata;
  logic [3:0]  rv_axi_wstrb;
  logic        rv_axi_wvalid;
  logic        rv_axi_wready = 1'b0;
  logic        rv_b_ready;
  logic        rv_b_valid = 1'b0;
  logic [1:0]  rv_b_response = '0;

  int total = 0;
  int passed = 0;
  int aw_cnt = 0;
  int w_cnt = 0;
  int b_cnt = 0;

  axi_lite_master_arbiter #(
    .MASTERS  (2),
    .BUSWIDTH (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .m_axi_araddr   (m_axi_araddr),
    .m_axi_arprot   (m_axi_arprot),
    .m_axi_arvalid  (m_axi_arvalid),
    .m_axi_arready  (m_axi_arready),
    .m_axi_rdata    (m_axi_rdata),
    .m_axi_rvalid   (m_axi_rvalid),
    .m_axi_rready   (m_axi_rready),
    .m_axi_awaddr   (m_axi_awaddr),
    .m_axi_awprot   (m_axi_awprot),
    .m_axi_awvalid  (m_axi_awvalid),
    .m_axi_awready  (m_axi_awready),
    .m_axi_wdata    (m_axi_wdata),
    .m_axi_wstrb    (m_axi_wstrb),
    .m_axi_wvalid   (m_axi_wvalid),
    .m_axi_wready   (m_axi_wready),
    .m_b_valid      (m_b_valid),
    .m_b_ready      (m_b_ready),
    .m_b_response   (m_b_response),
    .rv_axi_araddr  (rv_axi_araddr),
    .rv_axi_arprot  (rv_axi_arprot),
    .rv_axi_arvalid (rv_axi_arvalid),
    .rv_axi_arready (rv_axi_arready),
    .rv_axi_rdata   (rv_axi_rdata),
    .rv_axi_rvalid  (rv_axi_rvalid),
    .rv_axi_rready  (rv_axi_rready),
    .rv_axi_awaddr  (rv_axi_awaddr),
    .rv_axi_awprot  (rv_axi_awprot),
    .rv_axi_awvalid (rv_axi_awvalid),
    .rv_axi_awready (rv_axi_awready),
    .rv_axi_wdata   (rv_axi_wdata),
    .rv_axi_wstrb   (rv_axi_wstrb),
    .rv_axi_wvalid  (rv_axi_wvalid),
    .rv_axi_wready  (rv_axi_wready),
    .rv_b_ready     (rv_b_ready),
    .rv_b_valid     (rv_b_valid),
    .rv_b_response  (rv_b_response)
  );

  always #5 clk = ~clk;

  // Count beats accepted by the crossbar to catch duplicated AW/W/B transfers
  always @(posedge clk) begin
    if (rv_axi_awvalid && rv_axi_awready) aw_cnt <= aw_cnt + 1;
    if (rv_axi_wvalid && rv_axi_wready)   w_cnt  <= w_cnt + 1;
    if (rv_b_valid && rv_b_ready)         b_cnt  <= b_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int g;
  int waited;

  initial begin
    // Reset: every output is zero while rst is high
    #2 rst = 1'b1;
    #1;
    chk("rst_arvalid", 64'(rv_axi_arvalid), 64'd0);
    chk("rst_arready", 64'(m_axi_arready), 64'd0);
    chk("rst_bready", 64'(rv_b_ready), 64'd0);
    chk("rst_rdata", m_axi_rdata, 64'd0);
    tick();
    tick();
    rst = 1'b0;

    // Single read by master 1
    m_axi_araddr  = {32'h1000_0004, 32'h0};
    m_axi_arprot  = {3'b010, 3'b000};
    m_axi_arvalid = 2'b10;
    #1 chk("rd1_arb_cycle", 64'(rv_axi_arvalid), 64'd0);
    tick();
    chk("rd1_arvalid", 64'(rv_axi_arvalid), 64'd1);
    chk("rd1_araddr", 64'(rv_axi_araddr), 64'h1000_0004);
    chk("rd1_arprot", 64'(rv_axi_arprot), 64'd2);
    rv_axi_arready = 1'b1;
    #1 chk("rd1_arready", 64'(m_axi_arready), 64'b10);
    tick();
    m_axi_arvalid  = 2'b00;
    rv_axi_arready = 1'b0;
    rv_axi_rvalid  = 1'b1;
    rv_axi_rdata   = 32'hDEAD_BEEF;
    m_axi_rready   = 2'b10;
    #1;
    chk("rd1_rvalid", 64'(m_axi_rvalid), 64'b10);
    chk("rd1_rdata", m_axi_rdata, 64'hDEAD_BEEF_0000_0000);
    chk("rd1_rready", 64'(rv_axi_rready), 64'd1);
    tick();
    rv_axi_rvalid = 1'b0;
    #1 chk("rd1_retired", 64'(m_axi_rvalid), 64'd0);

    // Contention: both masters read continuously against a zero-wait slave
    m_axi_araddr   = {32'h0000_00B0, 32'h0000_00A0};
    m_axi_arvalid  = 2'b11;
    rv_axi_arready = 1'b1;
    rv_axi_rvalid  = 1'b1;
    rv_axi_rdata   = 32'h1234_5678;
    m_axi_rready   = 2'b11;
    g = 0;
    for (int k = 0; k < 8; k++) begin
      waited = 0;
      while (!rv_axi_arvalid && waited < 8) begin
        tick();
        waited++;
      end
      chk("rr_ar_wait", 64'(waited), 64'd1);
      chk("rr_grant", 64'(m_axi_arready), 64'(1 << g));
      chk("rr_araddr", 64'(rv_axi_araddr), (g == 0) ? 64'hA0 : 64'hB0);
      tick();
      tick();
`ifdef ARB_FIXED_PRIORITY_EN
      g = 0;
`else
      g = 1 - g;
`endif
    end
    m_axi_arvalid  = 2'b00;
    rv_axi_arready = 1'b0;
    rv_axi_rvalid  = 1'b0;
    m_axi_rready   = 2'b00;

    // Write by master 0: W accepted two cycles before AW, SLVERR passed back
    m_axi_awaddr   = {32'h0, 32'h2000_0010};
    m_axi_awprot   = {3'b000, 3'b001};
    m_axi_wdata    = {32'h0, 32'h1122_3344};
    m_axi_wstrb    = 8'h0F;
    m_axi_awvalid  = 2'b01;
    m_axi_wvalid   = 2'b01;
    rv_axi_wready  = 1'b1;
    tick();
    chk("wr1_awvalid", 64'(rv_axi_awvalid), 64'd1);
    chk("wr1_awaddr", 64'(rv_axi_awaddr), 64'h2000_0010);
    chk("wr1_wdata", 64'(rv_axi_wdata), 64'h1122_3344);
    chk("wr1_wstrb", 64'(rv_axi_wstrb), 64'hF);
    chk("wr1_wready", 64'(m_axi_wready), 64'b01);
    chk("wr1_awready_low", 64'(m_axi_awready), 64'd0);
    tick();
    chk("wr1_wvalid_masked", 64'(rv_axi_wvalid), 64'd0);
    chk("wr1_wready_masked", 64'(m_axi_wready), 64'd0);
    chk("wr1_aw_pending", 64'(rv_axi_awvalid), 64'd1);
    tick();
    rv_axi_awready = 1'b1;
    #1 chk("wr1_awready", 64'(m_axi_awready), 64'b01);
    tick();
    m_axi_awvalid  = 2'b00;
    m_axi_wvalid   = 2'b00;
    rv_axi_awready = 1'b0;
    rv_axi_wready  = 1'b0;
    rv_b_valid     = 1'b1;
    rv_b_response  = 2'b10;
    m_b_ready      = 2'b01;
    #1;
    chk("wr1_resp_noaw", 64'(rv_axi_awvalid), 64'd0);
    chk("wr1_bvalid", 64'(m_b_valid), 64'b01);
    chk("wr1_bresp", 64'(m_b_response), 64'b0010);
    tick();
    rv_b_valid = 1'b0;
    m_b_ready  = 2'b00;
    #1;
    chk("wr1_retired", 64'(m_b_valid), 64'd0);
    chk("wr1_aw_beats", 64'(aw_cnt), 64'd1);
    chk("wr1_w_beats", 64'(w_cnt), 64'd1);
    chk("wr1_b_beats", 64'(b_cnt), 64'd1);

    // Write by master 1 with AW and W accepted in the same cycle
    m_axi_awaddr   = {32'h3000_0020, 32'h0};
    m_axi_wdata    = {32'hA5A5_5A5A, 32'h0};
    m_axi_wstrb    = 8'hC0;
    m_axi_awvalid  = 2'b10;
    m_axi_wvalid   = 2'b10;
    rv_axi_awready = 1'b1;
    rv_axi_wready  = 1'b1;
    tick();
    chk("wr2_awready", 64'(m_axi_awready), 64'b10);
    chk("wr2_wready", 64'(m_axi_wready), 64'b10);
    chk("wr2_wstrb", 64'(rv_axi_wstrb), 64'hC);
    tick();
    m_axi_awvalid  = 2'b00;
    m_axi_wvalid   = 2'b00;
    rv_axi_awready = 1'b0;
    rv_axi_wready  = 1'b0;
    rv_b_valid     = 1'b1;
    rv_b_response  = 2'b10;
    m_b_ready      = 2'b10;
    #1;
    chk("wr2_bvalid", 64'(m_b_valid), 64'b10);
    chk("wr2_bresp", 64'(m_b_response), 64'b1000);
    tick();
    rv_b_valid = 1'b0;
    m_b_ready  = 2'b00;
    #1;
    chk("wr2_aw_beats", 64'(aw_cnt), 64'd2);
    chk("wr2_w_beats", 64'(w_cnt), 64'd2);
    chk("wr2_b_beats", 64'(b_cnt), 64'd2);

    // Concurrency: master 0 reads while master 1 writes
    m_axi_araddr   = {32'h0, 32'h4000_0000};
    m_axi_arvalid  = 2'b01;
    m_axi_awvalid  = 2'b10;
    m_axi_wvalid   = 2'b10;
    rv_axi_arready = 1'b1;
    rv_axi_awready = 1'b1;
    rv_axi_wready  = 1'b1;
    rv_axi_rvalid  = 1'b1;
    rv_axi_rdata   = 32'hCAFE_F00D;
    rv_b_valid     = 1'b1;
    rv_b_response  = 2'b00;
    m_axi_rready   = 2'b01;
    m_b_ready      = 2'b10;
    tick();
    chk("cc_arvalid", 64'(rv_axi_arvalid), 64'd1);
    chk("cc_awvalid", 64'(rv_axi_awvalid), 64'd1);
    chk("cc_arready", 64'(m_axi_arready), 64'b01);
    chk("cc_awready", 64'(m_axi_awready), 64'b10);
    tick();
    m_axi_arvalid = 2'b00;
    m_axi_awvalid = 2'b00;
    m_axi_wvalid  = 2'b00;
    #1;
    chk("cc_rvalid", 64'(m_axi_rvalid), 64'b01);
    chk("cc_rdata", m_axi_rdata, 64'h0000_0000_CAFE_F00D);
    chk("cc_bvalid", 64'(m_b_valid), 64'b10);
    tick();
    chk("cc_r_done", 64'(m_axi_rvalid), 64'd0);
    chk("cc_b_done", 64'(m_b_valid), 64'd0);
    rv_axi_arready = 1'b0;
    rv_axi_awready = 1'b0;
    rv_axi_wready  = 1'b0;
    rv_axi_rvalid  = 1'b0;
    rv_b_valid     = 1'b0;
    m_axi_rready   = 2'b00;
    m_b_ready      = 2'b00;

    // Backpressure: B stalled by master 0 while master 1 requests a write
    m_axi_awaddr   = {32'h5000_0001, 32'h5000_0000};
    m_axi_awvalid  = 2'b01;
    m_axi_wvalid   = 2'b01;
    rv_axi_awready = 1'b1;
    rv_axi_wready  = 1'b1;
    tick();
    tick();
    m_axi_awvalid = 2'b10;
    m_axi_wvalid  = 2'b10;
    rv_b_valid    = 1'b1;
    rv_b_response = 2'b00;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_bvalid_held", 64'(m_b_valid), 64'b01);
      chk("bp_aw_blocked", 64'(rv_axi_awvalid), 64'd0);
      tick();
    end
    m_b_ready = 2'b01;
    #1 chk("bp_bready", 64'(rv_b_ready), 64'd1);
    tick();
    rv_b_valid = 1'b0;
    m_b_ready  = 2'b00;
    #1 chk("bp_idle_arb", 64'(rv_axi_awvalid), 64'd0);
    tick();
    chk("bp_m1_aw", 64'(rv_axi_awvalid), 64'd1);
    chk("bp_m1_awaddr", 64'(rv_axi_awaddr), 64'h5000_0001);
    chk("bp_m1_awready", 64'(m_axi_awready), 64'b10);
    tick();
    m_axi_awvalid = 2'b00;
    m_axi_wvalid  = 2'b00;
    rv_b_valid    = 1'b1;
    m_b_ready     = 2'b10;
    tick();
    rv_b_valid     = 1'b0;
    m_b_ready      = 2'b00;
    rv_axi_awready = 1'b0;
    rv_axi_wready  = 1'b0;

    // Reset asserted mid-read by master 0; after release master 0 wins again
    m_axi_araddr   = {32'h0000_0BBB, 32'h0000_0AAA};
    m_axi_arvalid  = 2'b01;
    tick();
    rv_axi_arready = 1'b1;
    tick();
    m_axi_arvalid  = 2'b00;
    rv_axi_arready = 1'b0;
    rv_axi_rvalid  = 1'b1;
    rv_axi_rdata   = 32'h0000_55AA;
    m_axi_rready   = 2'b01;
    #1 chk("rr6_rvalid", 64'(m_axi_rvalid), 64'b01);
    #2 rst = 1'b1;
    #1;
    chk("arst_rvalid", 64'(m_axi_rvalid), 64'd0);
    chk("arst_rdata", m_axi_rdata, 64'd0);
    chk("arst_rready", 64'(rv_axi_rready), 64'd0);
    tick();
    tick();
    rst            = 1'b0;
    rv_axi_rvalid  = 1'b0;
    m_axi_arvalid  = 2'b11;
    rv_axi_arready = 1'b1;
    tick();
    chk("post_rst_grant", 64'(m_axi_arready), 64'b01);
    chk("post_rst_araddr", 64'(rv_axi_araddr), 64'hAAA);
    tick();
    m_axi_arvalid  = 2'b00;
    rv_axi_arready = 1'b0;
    rv_axi_rvalid  = 1'b1;
    m_axi_rready   = 2'b11;
    tick();
    rv_axi_rvalid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
